// File: rtl/calc_pkg.sv
// Shared encodings for the smallCALC sequencing controller: FSM states, ALU ops,
// write-mux selects, register addresses and the per-state DP control word.
package calc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    EXEC   = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  localparam logic [1:0] S1_ALU    = 2'b00;
  localparam logic [1:0] S1_UNUSED = 2'b01;
  localparam logic [1:0] S1_IN2    = 2'b10;
  localparam logic [1:0] S1_IN1    = 2'b11;

  localparam logic [1:0] R_A   = 2'b00;
  localparam logic [1:0] R_B   = 2'b01;
  localparam logic [1:0] R_RES = 2'b10;

  typedef struct packed {
    logic [1:0] s1;
    logic [1:0] wa;
    logic       we;
    logic [1:0] raa;
    logic       rea;
    logic [1:0] rab;
    logic       reb;
    logic [1:0] c;
    logic       s2;
    logic       busy;
    logic       done;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = 16'h0000;

  // Full DP control word for a given state; the ALU code is forced to ADD in IDLE.
  function automatic ctrl_t decode_ctrl(input state_e st, input logic [1:0] op_v);
    ctrl_t w;
    w = CTRL_IDLE;
    case (st)
      IDLE: begin
        w = CTRL_IDLE;
      end
      LOAD_A: begin
        w.s1   = S1_IN1;
        w.wa   = R_A;
        w.we   = 1'b1;
        w.c    = op_v;
        w.busy = 1'b1;
      end
      LOAD_B: begin
        w.s1   = S1_IN2;
        w.wa   = R_B;
        w.we   = 1'b1;
        w.c    = op_v;
        w.busy = 1'b1;
      end
      EXEC: begin
        w.s1   = S1_ALU;
        w.wa   = R_RES;
        w.we   = 1'b1;
        w.raa  = R_A;
        w.rea  = 1'b1;
        w.rab  = R_B;
        w.reb  = 1'b1;
        w.c    = op_v;
        w.busy = 1'b1;
      end
      DONE: begin
        w.s1   = S1_UNUSED;
        w.wa   = R_RES;
        w.raa  = R_A;
        w.rea  = 1'b1;
        w.rab  = R_B;
        w.reb  = 1'b1;
        w.c    = op_v;
        w.s2   = 1'b1;
        w.busy = 1'b1;
        w.done = 1'b1;
      end
      default: begin
        w = CTRL_IDLE;
      end
    endcase
    return w;
  endfunction

endpackage

// File: rtl/calc_ctrl.sv
// Sequencing controller for the smallCALC datapath: one go pulse runs
// load R0, load R1, execute into R2, present result; counts completed operations.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [1:0]       op,
  output logic [1:0]       s1,
  output logic [1:0]       wa,
  output logic             we,
  output logic [1:0]       raa,
  output logic             rea,
  output logic [1:0]       rab,
  output logic             reb,
  output logic [1:0]       c,
  output logic             s2,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] op_count
);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl_q, ctrl_d;

  // Next state, op latch and completion counter; control word is pre-decoded
  // from the next state so the outputs come straight from flops.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d = LOAD_A;
          op_d    = op;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_A:  state_d = LOAD_B;
      LOAD_B:  state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE: begin
        state_d = IDLE;
        cnt_d   = cnt_q + CNT_W'(1'b1);
      end
      default: state_d = IDLE;
    endcase
    ctrl_d = decode_ctrl(state_d, op_d);
  end

  // State, op latch, counter and registered control word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      cnt_q   <= {CNT_W{1'b0}};
      ctrl_q  <= CTRL_IDLE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign s1       = ctrl_q.s1;
  assign wa       = ctrl_q.wa;
  assign we       = ctrl_q.we;
  assign raa      = ctrl_q.raa;
  assign rea      = ctrl_q.rea;
  assign rab      = ctrl_q.rab;
  assign reb      = ctrl_q.reb;
  assign c        = ctrl_q.c;
  assign s2       = ctrl_q.s2;
  assign busy     = ctrl_q.busy;
  assign done     = ctrl_q.done;
  assign op_count = cnt_q;

endmodule

// File: doc/calc_ctrl.md
Name: calc_ctrl

Overview:
- Sequencing controller for the smallCALC datapath (DP). It drives every DP control input: s1, wa, we, raa, rea, rab, reb, c and s2.
- A single go pulse starts a four-step sequence:
  - load in1 into R0;
  - load in2 into R1;
  - execute the ALU op and write the result to R2;
  - present the result on out.
- The block sits between the top-level user interface (buttons/switches) and DP. It replaces hand-driven control words.

Parameters:
- CNT_W, 4, width of the completed-operation counter op_count.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- go  input  1  start request; sampled only in IDLE.
- op  input  2  ALU op: 00 add, 01 sub, 10 and, 11 xor. Latched when go is accepted.
- s1  output  2  DP write-data mux select: 11 in1, 10 in2, 00 ALU result, 01 unused.
- wa  output  2  DP register-file write address.
- we  output  1  DP register-file write enable.
- raa  output  2  DP read-port A address.
- rea  output  1  DP read-port A enable.
- rab  output  2  DP read-port B address.
- reb  output  1  DP read-port B enable.
- c  output  2  DP ALU control; equals the latched op.
- s2  output  1  DP output enable; 1 drives the ALU result onto out.
- busy  output  1  high from LOAD_A through DONE.
- done  output  1  one-cycle pulse in DONE; DP out is valid in this cycle.
- op_count  output  CNT_W  number of completed operations; wraps modulo 2^CNT_W.

Behaviour:
- FSM states: IDLE, LOAD_A, LOAD_B, EXEC, DONE. Encoding is held in the package.
- Transitions:
  - IDLE -> LOAD_A when go=1; otherwise stay in IDLE.
  - LOAD_A -> LOAD_B, LOAD_B -> EXEC, EXEC -> DONE, DONE -> IDLE, all unconditional.
- Moore outputs are decoded from the state register and op_q only. There is no combinational path from go or op to any output.
- Control words per state (s1, wa, we, raa, rea, rab, reb, s2):
  - IDLE: 00, 00, 0, 00, 0, 00, 0, 0.
  - LOAD_A: 11, 00, 1, 00, 0, 00, 0, 0.
  - LOAD_B: 10, 01, 1, 00, 0, 00, 0, 0.
  - EXEC: 00, 10, 1, 00, 1, 01, 1, 0.
  - DONE: 01, 10, 0, 00, 1, 01, 1, 1; done=1.
- c = op_q in every state except IDLE, where c=00.
- Latency:
  - go is high in cycle N; LOAD_A runs in N+1, LOAD_B in N+2, EXEC in N+3, DONE in N+4.
  - IDLE is reached in N+5, so the next go is accepted at the edge ending N+5 at the earliest.
- Register writes land at the edge ending LOAD_A, LOAD_B and EXEC.
- in1 must be stable through LOAD_A and in2 through LOAD_B. These are user-side requirements; the controller does not latch data.
- op is captured into op_q on the accepting edge. Changes to op while busy have no effect.
- go while busy is ignored, not queued. go held high continuously restarts a sequence at every IDLE visit.
- op_count increments by 1 on the edge leaving DONE. It wraps from 2^CNT_W-1 to 0.
- Reset (rst_n=0 at a rising edge) applies in any state, including mid-sequence:
  - state goes to IDLE and op_q to 00;
  - op_count goes to 0, and an aborted sequence does not increment it;
  - all outputs take IDLE values: s1=00, wa=00, we=0, raa=00, rea=0, rab=00, reb=0, c=00, s2=0, busy=0, done=0;
  - go is ignored while rst_n=0.
- Arithmetic follows DP 3-bit semantics. The result is modulo 8 (sub wraps: 2-5 = 5). The controller performs no arithmetic except op_count.

Decomposition:
- Package calc_pkg holds:
  - state localparams (IDLE..DONE);
  - ALU op codes (OP_ADD..OP_XOR);
  - s1 select codes (S1_IN1, S1_IN2, S1_ALU);
  - register addresses (R_A=00, R_B=01, R_RES=10).
- No sub-module: one FSM, a 2-bit op latch and one counter. The bench instantiates calc_ctrl and DP together as calc_top for end-to-end checks.

Test Plan:
- Reset, then in1=3, in2=4, op=00, go pulse -> busy high for 4 cycles; at DONE, out=7, done=1, s2=1; op_count=1 afterwards.
- in1=2, in2=5, op=01 -> out=5 at DONE (wrap). Then op=10 gives 0; op=11 gives 7.
- Start an op=00 sequence, then pulse go and change op to 11 during LOAD_B -> no restart; c stays 00 until IDLE; out=in1+in2; done pulses exactly once.
- rst_n=0 during EXEC -> next cycle all outputs at IDLE values, op_count=0, no done; a fresh go then completes normally.
- go held high for 20 cycles with CNT_W=2 -> four sequences complete back-to-back, 5 cycles apart; op_count runs 1, 2, 3, 0.
- Per-state control check: compare the full control word against the table in every state, for all 4 ops × 64 in1/in2 combinations, checking out at each DONE.
